move_input_conditioner: RTL and testbench

Input-conditioning stage between the board's raw push-buttons/slide switches and the game state machine. It synchronises and debounces the select and clear keys and snapshots the nine move switches at the select press. On select release it emits exactly one registered commit event per physical press: a valid square index, a malformed-move error, or nothing if the press was aborted. This replaces ad-hoc button polling in the game FSM; the FSM consumes only single-cycle pulses.

---
 rtl/move_input_conditioner_if.sv | 37 +++
 rtl/move_input_conditioner.sv | 175 +++++++++++++++++
 tb/tb_move_input_conditioner.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_input_conditioner_if.sv
// Key, switch and commit-pulse bundle between the board inputs and the game FSM.
// master drives the raw inputs and busy; slave is the conditioner.
interface move_input_conditioner_if;
    logic       key_select_n;
    logic       key_clear_n;
    logic [8:0] sw;
    logic       busy;
    logic       move_valid;
    logic [3:0] move_sq;
    logic       move_err;
    logic       clear_req;
    logic       select_level;

    modport master (
        output key_select_n,
        output key_clear_n,
        output sw,
        output busy,
        input  move_valid,
        input  move_sq,
        input  move_err,
        input  clear_req,
        input  select_level
    );

    modport slave (
        input  key_select_n,
        input  key_clear_n,
        input  sw,
        input  busy,
        output move_valid,
        output move_sq,
        output move_err,
        output clear_req,
        output select_level
    );
endinterface

// File: rtl/move_input_conditioner.sv
// Synchronise and debounce select/clear keys, snapshot the move switches on a
// select press, and emit one registered commit pulse per physical press.
module move_input_conditioner #(
    parameter int TICK_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     rst,
    move_input_conditioner_if.slave  io
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_TICKS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    localparam int KSEL = 0;
    localparam int KCLR = 1;

    // Synchronisers: bit 0 = select, bit 1 = clear (active-low, idle high)
    logic [1:0]          key_s1_q, key_s1_d;
    logic [1:0]          key_s2_q, key_s2_d;
    logic [8:0]          sw_s1_q, sw_s1_d;
    logic [8:0]          sw_s2_q, sw_s2_d;

    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic                tick;

    logic [1:0]          stable_q, stable_d;
    logic [1:0]          stable_prev_q, stable_prev_d;
    logic [1:0][CW-1:0]  db_cnt_q, db_cnt_d;

    logic                press_sel;
    logic                rel_sel;
    logic                press_clr;

    logic [0:0]          state_q, state_d;
    logic [8:0]          snap_q, snap_d;
    logic                snap_one_hot;
    logic [3:0]          snap_idx;

    logic                move_valid_q, move_valid_d;
    logic                move_err_q, move_err_d;
    logic                clear_req_q, clear_req_d;
    logic [3:0]          move_sq_q, move_sq_d;

    always_comb begin
        key_s1_d = {io.key_clear_n, io.key_select_n};
        key_s2_d = key_s1_q;
        sw_s1_d  = io.sw;
        sw_s2_d  = sw_s1_q;
    end

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // A key level is accepted only after DEBOUNCE_TICKS consecutive
    // disagreeing ticks; any agreeing tick restarts the count.
    always_comb begin
        stable_d      = stable_q;
        db_cnt_d      = db_cnt_q;
        stable_prev_d = stable_q;
        for (int k = 0; k < 2; k++) begin
            if (tick) begin
                if (key_s2_q[k] != stable_q[k]) begin
                    if (db_cnt_q[k] == DB_LAST) begin
                        stable_d[k] = key_s2_q[k];
                        db_cnt_d[k] = '0;
                    end else begin
                        db_cnt_d[k] = db_cnt_q[k] + CW'(1);
                    end
                end else begin
                    db_cnt_d[k] = '0;
                end
            end
        end
    end

    always_comb begin
        press_sel = stable_prev_q[KSEL] & ~stable_q[KSEL];
        rel_sel   = ~stable_prev_q[KSEL] & stable_q[KSEL];
        press_clr = stable_prev_q[KCLR] & ~stable_q[KCLR];
    end

    always_comb begin
        snap_one_hot = (snap_q != 9'd0) &&
                       ((snap_q & (snap_q - 9'd1)) == 9'd0);
        snap_idx = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (snap_q[i]) snap_idx = 4'(i);
        end
    end

    // Clear dominates: it aborts a held press and masks a same-cycle release.
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        move_valid_d = 1'b0;
        move_err_d   = 1'b0;
        clear_req_d  = 1'b0;
        move_sq_d    = move_sq_q;
        if (press_clr) begin
            clear_req_d = 1'b1;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press_sel) begin
                        snap_d  = sw_s2_q;
                        state_d = HELD;
                    end
                end
                HELD: begin
                    if (rel_sel) begin
                        state_d = IDLE;
                        if (snap_one_hot && !io.busy) begin
                            move_valid_d = 1'b1;
                            move_sq_d    = snap_idx;
                        end else begin
                            move_err_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
        if (rst) begin
            key_s1_q      <= 2'b11;
            key_s2_q      <= 2'b11;
            sw_s1_q       <= '0;
            sw_s2_q       <= '0;
            tick_cnt_q    <= '0;
            stable_q      <= 2'b11;
            stable_prev_q <= 2'b11;
            db_cnt_q      <= '0;
            state_q       <= IDLE;
            snap_q        <= '0;
            move_valid_q  <= 1'b0;
            move_err_q    <= 1'b0;
            clear_req_q   <= 1'b0;
            move_sq_q     <= '0;
        end else begin
            key_s1_q      <= key_s1_d;
            key_s2_q      <= key_s2_d;
            sw_s1_q       <= sw_s1_d;
            sw_s2_q       <= sw_s2_d;
            tick_cnt_q    <= tick_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            db_cnt_q      <= db_cnt_d;
            state_q       <= state_d;
            snap_q        <= snap_d;
            move_valid_q  <= move_valid_d;
            move_err_q    <= move_err_d;
            clear_req_q   <= clear_req_d;
            move_sq_q     <= move_sq_d;
        end
    end

    assign io.move_valid   = move_valid_q;
    assign io.move_err     = move_err_q;
    assign io.clear_req    = clear_req_q;
    assign io.move_sq      = move_sq_q;
    assign io.select_level = ~stable_q[KSEL];

endmodule

// File: tb/tb_move_input_conditioner.sv
// Scenario bench for move_input_conditioner: expected commit pulses are queued
// as stimulus is driven and matched against DUT pulses by a monitor.
module tb_move_input_conditioner;

    typedef struct {
        logic       v;
        logic       e;
        logic       c;
        logic [3:0] sq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    bit   sel_seen;

    move_input_conditioner_if io ();

    move_input_conditioner #(
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .io            (io)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (io.select_level) sel_seen = 1'b1;
    end

    // Every pulse seen must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (io.move_valid || io.move_err || io.clear_req)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse valid=%b err=%b clr=%b sq=%0d",
                         io.move_valid, io.move_err, io.clear_req, io.move_sq);
            end else begin
                e = exp_q.pop_front();
                if ({io.move_valid, io.move_err, io.clear_req} !== {e.v, e.e, e.c} ||
                    (e.v && io.move_sq !== e.sq)) begin
                    errors++;
                    $display("FAIL pulse got v/e/c=%b%b%b sq=%0d want v/e/c=%b%b%b sq=%0d",
                             io.move_valid, io.move_err, io.clear_req, io.move_sq,
                             e.v, e.e, e.c, e.sq);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic v, input logic e, input logic c,
                        input logic [3:0] sq);
        exp_t x;
        x.v = v; x.e = e; x.c = c; x.sq = sq;
        exp_q.push_back(x);
    endtask

    task automatic test_reset;
        cyc(3);
        checks++;
        if ({io.move_valid, io.move_err, io.clear_req, io.select_level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses got %b want 0000",
                     {io.move_valid, io.move_err, io.clear_req, io.select_level});
        end
        checks++;
        if (io.move_sq !== 4'd0) begin
            errors++;
            $display("FAIL reset_sq got %0d want 0", io.move_sq);
        end
        rst = 1'b0;
        cyc(5);
        checks++;
        if (io.select_level !== 1'b0) begin
            errors++;
            $display("FAIL idle_level got %b want 0", io.select_level);
        end
    endtask

    task automatic test_valid_move;
        io.sw = 9'b000010000;
        cyc(4);
        push(1, 0, 0, 4'd4);
        io.key_select_n = 1'b0;
        cyc(30);
        checks++;
        if (io.select_level !== 1'b1) begin
            errors++;
            $display("FAIL hold_level got %b want 1", io.select_level);
        end
        cyc(10);
        io.key_select_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL valid_drain got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (io.move_sq !== 4'd4) begin
            errors++;
            $display("FAIL valid_sq got %0d want 4", io.move_sq);
        end
    endtask

    task automatic test_malformed;
        io.sw = 9'b000000101;
        cyc(4);
        push(0, 1, 0, 4'd0);
        io.key_select_n = 1'b0;
        cyc(40);
        io.key_select_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL err_drain got %0d pending want 0", exp_q.size());
        end
        checks++;
        if (io.move_sq !== 4'd4) begin
            errors++;
            $display("FAIL err_keeps_sq got %0d want 4", io.move_sq);
        end
    endtask

    task automatic test_bounce;
        io.sw = 9'b000000001;
        sel_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            io.key_select_n = ~io.key_select_n;
            cyc(3);
        end
        cyc(40);
        checks++;
        if (sel_seen !== 1'b0) begin
            errors++;
            $display("FAIL bounce_level got %b want 0", sel_seen);
        end
        push(1, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            io.key_select_n = ~io.key_select_n;
            cyc(3);
        end
        cyc(40);
        io.key_select_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0 || io.move_sq !== 4'd0) begin
            errors++;
            $display("FAIL bounce_commit got %0d pending sq=%0d want 0 pending sq=0",
                     exp_q.size(), io.move_sq);
        end
    endtask

    task automatic test_sw_change;
        io.sw = 9'b100000000;
        cyc(4);
        push(1, 0, 0, 4'd8);
        io.key_select_n = 1'b0;
        cyc(20);
        io.sw = 9'b000000001;
        cyc(20);
        io.key_select_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0 || io.move_sq !== 4'd8) begin
            errors++;
            $display("FAIL snap_sq got %0d pending sq=%0d want 0 pending sq=8",
                     exp_q.size(), io.move_sq);
        end
        io.sw = 9'b100000000;
        cyc(4);
        push(0, 1, 0, 4'd0);
        io.key_select_n = 1'b0;
        cyc(20);
        io.sw = 9'b000000001;
        cyc(20);
        io.busy = 1'b1;
        io.key_select_n = 1'b1;
        cyc(40);
        io.busy = 1'b0;
        checks++;
        if (exp_q.size() != 0 || io.move_sq !== 4'd8) begin
            errors++;
            $display("FAIL busy_err got %0d pending sq=%0d want 0 pending sq=8",
                     exp_q.size(), io.move_sq);
        end
    endtask

    task automatic test_clear_abort;
        io.sw = 9'b000000100;
        cyc(4);
        io.key_select_n = 1'b0;
        cyc(30);
        push(0, 0, 1, 4'd0);
        io.key_clear_n = 1'b0;
        cyc(30);
        io.key_clear_n = 1'b1;
        cyc(30);
        io.key_select_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0 || io.move_sq !== 4'd8) begin
            errors++;
            $display("FAIL clear_abort got %0d pending sq=%0d want 0 pending sq=8",
                     exp_q.size(), io.move_sq);
        end
    endtask

    task automatic test_clear_same_cycle;
        io.sw = 9'b000000100;
        cyc(4);
        io.key_select_n = 1'b0;
        cyc(30);
        push(0, 0, 1, 4'd0);
        io.key_select_n = 1'b1;
        io.key_clear_n  = 1'b0;
        cyc(30);
        io.key_clear_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0 || io.move_sq !== 4'd8) begin
            errors++;
            $display("FAIL clear_wins got %0d pending sq=%0d want 0 pending sq=8",
                     exp_q.size(), io.move_sq);
        end
    endtask

    task automatic test_reset_held;
        io.sw = 9'b001000000;
        cyc(4);
        io.key_select_n = 1'b0;
        cyc(30);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({io.move_valid, io.move_err, io.clear_req, io.select_level} !== 4'b0000 ||
            io.move_sq !== 4'd0) begin
            errors++;
            $display("FAIL async_reset got v/e/c/l=%b sq=%0d want 0000 sq=0",
                     {io.move_valid, io.move_err, io.clear_req, io.select_level},
                     io.move_sq);
        end
        cyc(3);
        rst = 1'b0;
        push(1, 0, 0, 4'd6);
        cyc(40);
        checks++;
        if (io.select_level !== 1'b1 || exp_q.size() != 1) begin
            errors++;
            $display("FAIL post_reset_press got level=%b pending=%0d want level=1 pending=1",
                     io.select_level, exp_q.size());
        end
        io.key_select_n = 1'b1;
        cyc(40);
        checks++;
        if (exp_q.size() != 0 || io.move_sq !== 4'd6) begin
            errors++;
            $display("FAIL post_reset_commit got %0d pending sq=%0d want 0 pending sq=6",
                     exp_q.size(), io.move_sq);
        end
    endtask

    initial begin
        io.key_select_n = 1'b1;
        io.key_clear_n  = 1'b1;
        io.sw           = 9'd0;
        io.busy         = 1'b0;
        sel_seen        = 1'b0;
        test_reset();
        test_valid_move();
        test_malformed();
        test_bounce();
        test_sw_change();
        test_clear_abort();
        test_clear_same_cycle();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
